fft_power_peak: RTL and testbench

//  Sits directly downstream of the fftmain output. Converts each bit-reversal-ordered complex bin

---
 rtl/fft_power_peak.sv | 125 ++++++++++++
 tb/tb_fft_power_peak.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_power_peak.sv
// fft_power_peak: per-bin power re^2+im^2 tagged with bin index, plus a per-frame peak report.
// Define FFT_PEAK_DC_SKIP_EN to exclude bin 0 from the peak search.
module fft_power_peak #(
  parameter int IWIDTH = 21,
  parameter int LGSIZE = 9,
  parameter int PWIDTH = 2*IWIDTH
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_ce,
  input  logic [2*IWIDTH-1:0] i_sample,
  input  logic                i_sync,
  output logic                o_valid,
  output logic [PWIDTH-1:0]   o_power,
  output logic [LGSIZE-1:0]   o_bin,
  output logic                o_peak_valid,
  output logic [LGSIZE-1:0]   o_peak_bin,
  output logic [PWIDTH-1:0]   o_peak_pwr,
  output logic                o_resync
);
  localparam int SQW = 2*IWIDTH - 1;
  localparam logic [LGSIZE-1:0] LAST_BIN = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic [LGSIZE-1:0]        count;
  logic signed [IWIDTH-1:0] in_re, in_im;
  logic                     accept;
  logic [LGSIZE-1:0]        in_bin;

  logic                     s1_vld;
  logic signed [IWIDTH-1:0] s1_re, s1_im;
  logic [LGSIZE-1:0]        s1_bin;

  logic                     s2_vld;
  logic [SQW-1:0]           s2_re_sq, s2_im_sq;
  logic [LGSIZE-1:0]        s2_bin;

  logic signed [2*IWIDTH-1:0] re_ext, im_ext;
  logic [SQW-1:0]           re_sq, im_sq;
  logic [PWIDTH-1:0]        pwr;
  logic                     peak_upd;
  logic [LGSIZE-1:0]        peak_bin;
  logic [PWIDTH-1:0]        peak_pwr;
  logic                     frame_done;

  assign in_re  = i_sample[2*IWIDTH-1:IWIDTH];
  assign in_im  = i_sample[IWIDTH-1:0];
  assign accept = i_ce && (i_sync || state == RUN);
  assign in_bin = i_sync ? '0 : count;

  // A square of a signed value is non-negative and at most 2**(2*IWIDTH-2), so the top bit is dropped.
  assign re_ext = {{IWIDTH{s1_re[IWIDTH-1]}}, s1_re};
  assign im_ext = {{IWIDTH{s1_im[IWIDTH-1]}}, s1_im};
  assign re_sq  = SQW'(re_ext * re_ext);
  assign im_sq  = SQW'(im_ext * im_ext);
  assign pwr    = PWIDTH'(s2_re_sq) + PWIDTH'(s2_im_sq);

`ifdef FFT_PEAK_DC_SKIP_EN
  assign peak_upd = (s2_bin == LGSIZE'(1)) || (s2_bin != '0 && pwr > peak_pwr);
`else
  assign peak_upd = (s2_bin == '0) || (pwr > peak_pwr);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      count        <= '0;
      s1_vld       <= 1'b0;
      s1_re        <= '0;
      s1_im        <= '0;
      s1_bin       <= '0;
      s2_vld       <= 1'b0;
      s2_re_sq     <= '0;
      s2_im_sq     <= '0;
      s2_bin       <= '0;
      peak_bin     <= '0;
      peak_pwr     <= '0;
      frame_done   <= 1'b0;
      o_valid      <= 1'b0;
      o_power      <= '0;
      o_bin        <= '0;
      o_peak_valid <= 1'b0;
      o_peak_bin   <= '0;
      o_peak_pwr   <= '0;
      o_resync     <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_resync     <= 1'b0;
      frame_done   <= 1'b0;
      // The report fires one clock after the last bin, whether or not the pipeline advances.
      o_peak_valid <= frame_done;
      if (frame_done) begin
        o_peak_bin <= peak_bin;
        o_peak_pwr <= peak_pwr;
      end
      if (i_ce) begin
        s1_vld <= accept;
        if (accept) begin
          s1_re    <= in_re;
          s1_im    <= in_im;
          s1_bin   <= in_bin;
          count    <= in_bin + LGSIZE'(1);
          state    <= RUN;
          o_resync <= i_sync && (state == RUN) && (count != '0);
        end
        s2_vld   <= s1_vld;
        s2_re_sq <= re_sq;
        s2_im_sq <= im_sq;
        s2_bin   <= s1_bin;
        if (s2_vld) begin
          o_valid    <= 1'b1;
          o_power    <= pwr;
          o_bin      <= s2_bin;
          frame_done <= (s2_bin == LAST_BIN);
          if (peak_upd) begin
            peak_bin <= s2_bin;
            peak_pwr <= pwr;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_power_peak.sv
// Bench for fft_power_peak with 8-bin frames: per-scenario tasks against a frame-level reference model.
module tb_fft_power_peak;
  localparam int IW = 21;
  localparam int LG = 3;
  localparam int N  = 8;
  localparam int PW = 42;
`ifdef FFT_PEAK_DC_SKIP_EN
  localparam bit DC_SKIP = 1'b1;
`else
  localparam bit DC_SKIP = 1'b0;
`endif

  logic          clk, reset, ce, sync;
  logic [2*IW-1:0] sample;
  logic          o_valid, o_peak_valid, o_resync;
  logic [PW-1:0] o_power, o_peak_pwr;
  logic [LG-1:0] o_bin, o_peak_bin;

  fft_power_peak #(.IWIDTH(IW), .LGSIZE(LG), .PWIDTH(PW)) dut (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_sample(sample), .i_sync(sync),
    .o_valid(o_valid), .o_power(o_power), .o_bin(o_bin),
    .o_peak_valid(o_peak_valid), .o_peak_bin(o_peak_bin), .o_peak_pwr(o_peak_pwr),
    .o_resync(o_resync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cyc; longint pwr; int bin; } ev_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  ev_t    exp_out[$], obs_out[$], exp_pk[$], obs_pk[$];
  int     exp_rs[$], obs_rs[$];
  bit     ce_at[int];
  bit     m_run;
  int     m_pos;
  longint fpow[N];
  ev_t    mon_e;

  always @(negedge clk) begin
    if (o_valid) begin
      mon_e.cyc = cyc; mon_e.pwr = longint'(o_power); mon_e.bin = int'(o_bin);
      obs_out.push_back(mon_e);
    end
    if (o_peak_valid) begin
      mon_e.cyc = cyc; mon_e.pwr = longint'(o_peak_pwr); mon_e.bin = int'(o_peak_bin);
      obs_pk.push_back(mon_e);
    end
    if (o_resync) obs_rs.push_back(cyc);
  end

  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 8)) - 4;
      1: return ($urandom_range(0, 1) != 0) ? -(1 << 20) : (1 << 20) - 1;
      default: return int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
    endcase
  endfunction

  task automatic clear_q();
    exp_out.delete(); obs_out.delete(); exp_pk.delete(); obs_pk.delete();
    exp_rs.delete(); obs_rs.delete();
  endtask

  // One clock: apply inputs, advance the frame-level model at the edge.
  task automatic drive(input bit c, input bit s, input int re, input int im);
    logic [IW-1:0] rr, mm;
    ev_t e;
    int bb;
    longint bp;
    rr = re[IW-1:0]; mm = im[IW-1:0];
    ce = c; sync = s; sample = {rr, mm};
    @(posedge clk);
    cyc++;
    ce_at[cyc] = c;
    if (c) begin
      if (s) begin
        if (m_run && m_pos != 0) exp_rs.push_back(cyc);
        m_pos = 0; m_run = 1'b1;
      end
      if (m_run) begin
        e.cyc = cyc; e.bin = m_pos;
        e.pwr = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        exp_out.push_back(e);
        fpow[m_pos] = e.pwr;
        if (m_pos == N - 1) begin
          bb = -1; bp = 0;
          for (int b = (DC_SKIP ? 1 : 0); b < N; b++)
            if (bb < 0 || fpow[b] > bp) begin bb = b; bp = fpow[b]; end
          e.bin = bb; e.pwr = bp;
          exp_pk.push_back(e);
        end
        m_pos = (m_pos + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b1; sync = 1'b1; sample = {$urandom, $urandom};
    repeat (2) begin @(posedge clk); cyc++; end
    @(negedge clk);
    reset = 1'b0; ce = 1'b0; sync = 1'b0;
    m_run = 1'b0; m_pos = 0;
    clear_q();
  endtask

  task automatic flush(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 12; k++) drive(1'b1, k == 0, rnd_val(), rnd_val());
    reset = 1'b1;
    @(posedge clk); cyc++;
    @(negedge clk);
    checks++;
    if ({o_valid, o_power, o_bin, o_peak_valid, o_peak_bin, o_peak_pwr, o_resync} !== '0) begin
      errors++;
      $display("FAIL reset_outputs valid=%0b pwr=%0d bin=%0d pk_v=%0b pk_bin=%0d pk_pwr=%0d rs=%0b, want all 0",
               o_valid, o_power, o_bin, o_peak_valid, o_peak_bin, o_peak_pwr, o_resync);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    for (int b = 0; b < N; b++) drive(1'b1, b == 0, (b == 5) ? 3 : 0, (b == 5) ? -4 : 0);
    flush(4);
    checks++;
    if (obs_out.size() < N) begin
      errors++; $display("FAIL basic_count got %0d want >=%0d", obs_out.size(), N);
    end
    for (int i = 0; i < N && i < obs_out.size(); i++) begin
      checks++;
      if (obs_out[i].bin !== i || obs_out[i].pwr !== ((i == 5) ? 64'd25 : 64'd0)) begin
        errors++; $display("FAIL basic_out[%0d] got bin %0d pwr %0d", i, obs_out[i].bin, obs_out[i].pwr);
      end
      checks++;
      if (obs_out[i].cyc !== exp_out[i].cyc + 2) begin
        errors++; $display("FAIL basic_latency[%0d] got cyc %0d want %0d", i, obs_out[i].cyc, exp_out[i].cyc + 2);
      end
    end
    checks++;
    if (obs_pk.size() !== 1 || obs_out.size() < N) begin
      errors++; $display("FAIL basic_peak_count got %0d want 1", obs_pk.size());
    end else if (obs_pk[0].bin !== 5 || obs_pk[0].pwr !== 64'd25 || obs_pk[0].cyc !== obs_out[N-1].cyc + 1) begin
      errors++;
      $display("FAIL basic_peak got bin %0d pwr %0d cyc %0d want 5 25 cyc %0d",
               obs_pk[0].bin, obs_pk[0].pwr, obs_pk[0].cyc, obs_out[N-1].cyc + 1);
    end
  endtask

  task automatic test_no_sync();
    do_reset();
    for (int k = 0; k < 40; k++) drive(1'($urandom_range(0, 1)), 1'b0, rnd_val(), rnd_val());
    checks++;
    if (obs_out.size() != 0 || obs_pk.size() != 0 || obs_rs.size() != 0) begin
      errors++;
      $display("FAIL no_sync got valid %0d peak %0d resync %0d want 0 0 0", obs_out.size(), obs_pk.size(), obs_rs.size());
    end
  endtask

  task automatic test_extreme();
    longint big;
    big = longint'(1) << 41;
    do_reset();
    for (int b = 0; b < N; b++) drive(1'b1, b == 0, -(1 << 20), -(1 << 20));
    flush(4);
    for (int i = 0; i < N && i < obs_out.size(); i++) begin
      checks++;
      if (obs_out[i].pwr !== big || obs_out[i].bin !== i) begin
        errors++; $display("FAIL extreme_out[%0d] got bin %0d pwr %0d want pwr %0d", i, obs_out[i].bin, obs_out[i].pwr, big);
      end
    end
    checks++;
    if (obs_pk.size() !== 1) begin
      errors++; $display("FAIL extreme_peak_count got %0d want 1", obs_pk.size());
    end else if (obs_pk[0].pwr !== big || obs_pk[0].bin !== (DC_SKIP ? 1 : 0)) begin
      errors++; $display("FAIL extreme_peak got bin %0d pwr %0d want bin %0d pwr %0d",
                         obs_pk[0].bin, obs_pk[0].pwr, DC_SKIP ? 1 : 0, big);
    end
  endtask

  task automatic test_ties();
    do_reset();
    for (int b = 0; b < N; b++) drive(1'b1, b == 0, (b == 2) ? 3 : 0, (b == 6) ? -3 : 0);
    // Second frame runs on without i_sync.
    for (int b = 0; b < N; b++)
      drive(1'b1, 1'b0, (b == 0) ? 6 : (b == 3) ? 1 : (b == 2) ? 3 : 0, (b == 0) ? 8 : (b == 3) ? 7 : 0);
    flush(4);
    checks++;
    if (obs_pk.size() !== 2) begin
      errors++; $display("FAIL ties_peak_count got %0d want 2", obs_pk.size());
    end else begin
      checks++;
      if (obs_pk[0].bin !== 2 || obs_pk[0].pwr !== 64'd9) begin
        errors++; $display("FAIL ties_peak0 got bin %0d pwr %0d want 2 9", obs_pk[0].bin, obs_pk[0].pwr);
      end
      checks++;
      if (obs_pk[1].bin !== (DC_SKIP ? 3 : 0) || obs_pk[1].pwr !== (DC_SKIP ? 64'd50 : 64'd100)) begin
        errors++; $display("FAIL ties_peak1 got bin %0d pwr %0d want %0d %0d",
                           obs_pk[1].bin, obs_pk[1].pwr, DC_SKIP ? 3 : 0, DC_SKIP ? 50 : 100);
      end
    end
  endtask

  task automatic test_resync();
    int rs_cyc, n;
    do_reset();
    for (int b = 0; b < 4; b++) drive(1'b1, b == 0, rnd_val(), rnd_val());
    drive(1'b1, 1'b1, rnd_val(), rnd_val());
    rs_cyc = cyc;
    for (int b = 1; b < N; b++) drive(1'b1, 1'b0, rnd_val(), rnd_val());
    drive(1'b1, 1'b1, rnd_val(), rnd_val());
    n = exp_out.size();
    flush(4);
    checks++;
    if (obs_rs.size() !== 1 || obs_rs[0] !== rs_cyc) begin
      errors++; $display("FAIL resync_pulse got %0d pulses first cyc %0d want 1 at %0d",
                         obs_rs.size(), (obs_rs.size() > 0) ? obs_rs[0] : -1, rs_cyc);
    end
    checks++;
    if (obs_out.size() < n) begin
      errors++; $display("FAIL resync_count got %0d want >=%0d", obs_out.size(), n);
    end
    for (int i = 0; i < n && i < obs_out.size(); i++) begin
      checks++;
      if (obs_out[i].bin !== exp_out[i].bin || obs_out[i].pwr !== exp_out[i].pwr) begin
        errors++; $display("FAIL resync_out[%0d] got bin %0d pwr %0d want bin %0d pwr %0d",
                           i, obs_out[i].bin, obs_out[i].pwr, exp_out[i].bin, exp_out[i].pwr);
      end
    end
    checks++;
    if (obs_pk.size() !== 1 || exp_pk.size() < 1) begin
      errors++; $display("FAIL resync_peak_count got %0d want 1", obs_pk.size());
    end else if (obs_pk[0].bin !== exp_pk[0].bin || obs_pk[0].pwr !== exp_pk[0].pwr) begin
      errors++; $display("FAIL resync_peak got bin %0d pwr %0d want bin %0d pwr %0d",
                         obs_pk[0].bin, obs_pk[0].pwr, exp_pk[0].bin, exp_pk[0].pwr);
    end
  endtask

  task automatic test_random();
    int n, np, nr;
    int lastc[$];
    do_reset();
    for (int k = 0; k < 500; k++)
      drive((k == 0) || ($urandom_range(0, 3) != 0), (k == 0) || ($urandom_range(0, 59) == 0), rnd_val(), rnd_val());
    n = exp_out.size(); np = exp_pk.size(); nr = exp_rs.size();
    flush(4);
    checks++;
    if (obs_out.size() < n || obs_pk.size() < np || obs_rs.size() != nr) begin
      errors++; $display("FAIL random_counts got out %0d pk %0d rs %0d want >=%0d >=%0d %0d",
                         obs_out.size(), obs_pk.size(), obs_rs.size(), n, np, nr);
    end
    for (int i = 0; i < n && i < obs_out.size(); i++) begin
      checks++;
      if (obs_out[i].bin !== exp_out[i].bin || obs_out[i].pwr !== exp_out[i].pwr) begin
        errors++; $display("FAIL random_out[%0d] got bin %0d pwr %0d want bin %0d pwr %0d",
                           i, obs_out[i].bin, obs_out[i].pwr, exp_out[i].bin, exp_out[i].pwr);
      end
      if (obs_out[i].bin == N - 1) lastc.push_back(obs_out[i].cyc);
    end
    for (int i = 0; i < np && i < obs_pk.size(); i++) begin
      checks++;
      if (obs_pk[i].bin !== exp_pk[i].bin || obs_pk[i].pwr !== exp_pk[i].pwr ||
          i >= lastc.size() || obs_pk[i].cyc !== lastc[i] + 1) begin
        errors++; $display("FAIL random_peak[%0d] got bin %0d pwr %0d cyc %0d want bin %0d pwr %0d",
                           i, obs_pk[i].bin, obs_pk[i].pwr, obs_pk[i].cyc, exp_pk[i].bin, exp_pk[i].pwr);
      end
    end
    for (int i = 0; i < nr && i < obs_rs.size(); i++) begin
      checks++;
      if (obs_rs[i] !== exp_rs[i]) begin
        errors++; $display("FAIL random_resync[%0d] got cyc %0d want %0d", i, obs_rs[i], exp_rs[i]);
      end
    end
  endtask

  task automatic test_toggle_reset();
    do_reset();
    for (int k = 0; k < 2*N; k++)
      drive(k % 2 == 0, k == 0, (k == 10) ? 3 : 0, (k == 10) ? -4 : 0);
    for (int k = 0; k < 8; k++) drive(k % 2 == 0, 1'b0, 0, 0);
    checks++;
    if (obs_out.size() < N) begin
      errors++; $display("FAIL toggle_count got %0d want >=%0d", obs_out.size(), N);
    end
    for (int i = 0; i < N && i < obs_out.size(); i++) begin
      checks++;
      if (obs_out[i].bin !== i || obs_out[i].pwr !== ((i == 5) ? 64'd25 : 64'd0) ||
          !ce_at.exists(obs_out[i].cyc) || !ce_at[obs_out[i].cyc]) begin
        errors++; $display("FAIL toggle_out[%0d] got bin %0d pwr %0d at cyc %0d", i, obs_out[i].bin, obs_out[i].pwr, obs_out[i].cyc);
      end
    end
    checks++;
    if (obs_pk.size() !== 1 || obs_out.size() < N) begin
      errors++; $display("FAIL toggle_peak_count got %0d want 1", obs_pk.size());
    end else if (obs_pk[0].bin !== 5 || obs_pk[0].pwr !== 64'd25 || obs_pk[0].cyc !== obs_out[N-1].cyc + 1) begin
      errors++; $display("FAIL toggle_peak got bin %0d pwr %0d cyc %0d", obs_pk[0].bin, obs_pk[0].pwr, obs_pk[0].cyc);
    end
    for (int k = 0; k < 6; k++) drive(k % 2 == 0, k == 0, rnd_val(), rnd_val());
    do_reset();
    checks++;
    if ({o_valid, o_power, o_bin, o_peak_valid, o_peak_bin, o_peak_pwr, o_resync} !== '0) begin
      errors++; $display("FAIL midreset_outputs valid=%0b pwr=%0d bin=%0d pk_v=%0b pk_bin=%0d pk_pwr=%0d",
                         o_valid, o_power, o_bin, o_peak_valid, o_peak_bin, o_peak_pwr);
    end
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, rnd_val(), rnd_val());
    checks++;
    if (obs_out.size() != 0 || obs_pk.size() != 0 || obs_rs.size() != 0) begin
      errors++; $display("FAIL midreset_idle got valid %0d peak %0d resync %0d want 0 0 0",
                         obs_out.size(), obs_pk.size(), obs_rs.size());
    end
    for (int b = 0; b < N; b++) drive(1'b1, b == 0, (b == 5) ? 3 : 0, (b == 5) ? -4 : 0);
    flush(4);
    checks++;
    if (obs_pk.size() !== 1) begin
      errors++; $display("FAIL postreset_peak_count got %0d want 1", obs_pk.size());
    end else if (obs_pk[0].bin !== 5 || obs_pk[0].pwr !== 64'd25) begin
      errors++; $display("FAIL postreset_peak got bin %0d pwr %0d want 5 25", obs_pk[0].bin, obs_pk[0].pwr);
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; sync = 1'b0; sample = '0;
    m_run = 1'b0; m_pos = 0;
    for (int b = 0; b < N; b++) fpow[b] = 0;
    test_reset();
    test_basic();
    test_no_sync();
    test_extreme();
    test_ties();
    test_resync();
    test_random();
    test_toggle_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
